// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for nand_cpu: steps each instruction through FETCH..WRITEBACK,
// drives datapath stage strobes, and handles wait states, bus timeout, interrupts and perf counters.
module multicycle_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32,
  parameter bit SKIP_MEM       = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             imem_ready,
  input  logic             dec_is_mem,
  input  logic             dec_is_halt,
  input  logic             dec_writes_reg,
  input  logic             dmem_ready,
  input  logic             irq,
  output logic             imem_req,
  output logic             ir_load,
  output logic             reg_read_en,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             wb_en,
  output logic             pc_en,
  output logic             irq_ack,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       stage,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } stage_e;

  localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  stage_e            stage_q, stage_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cycle_q, instr_q;
  logic              retire;

  always_comb begin
    stage_d  = stage_q;
    wait_d   = wait_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    retire   = 1'b0;
    case (stage_q)
      S_FETCH: begin
        if (imem_ready) begin
          stage_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          stage_d  = S_HALTED;
          halted_d = 1'b1;
          fault_d  = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (dec_is_halt) begin
          stage_d  = S_HALTED;
          halted_d = 1'b1;
          retire   = 1'b1;
        end else begin
          stage_d = S_EXECUTE;
        end
      end
      S_EXECUTE: stage_d = (dec_is_mem || !SKIP_MEM) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        // Ready in the last allowed wait cycle still completes the access.
        if (!dec_is_mem || dmem_ready) begin
          stage_d = S_WRITEBACK;
        end else if (wait_q == WAIT_LAST) begin
          stage_d  = S_HALTED;
          halted_d = 1'b1;
          fault_d  = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WRITEBACK: begin
        stage_d = S_FETCH;
        retire  = 1'b1;
      end
      default: stage_d = S_HALTED;
    endcase
    if (stage_d != stage_q) wait_d = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stage_q  <= S_FETCH;
      wait_q   <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      cycle_q  <= '0;
      instr_q  <= '0;
    end else begin
      stage_q  <= stage_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      if (stage_q != S_HALTED) cycle_q <= cycle_q + CNT_W'(1);
      if (retire) instr_q <= instr_q + CNT_W'(1);
    end
  end

  // Strobes are held low while reset is asserted, even though stage already reads FETCH.
  always_comb begin
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    reg_read_en = 1'b0;
    alu_en      = 1'b0;
    dmem_req    = 1'b0;
    wb_en       = 1'b0;
    pc_en       = 1'b0;
    irq_ack     = 1'b0;
    if (n_rst) begin
      case (stage_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ready;
        end
        S_DECODE:  reg_read_en = 1'b1;
        S_EXECUTE: alu_en = 1'b1;
        S_MEMORY:  dmem_req = dec_is_mem;
        S_WRITEBACK: begin
          wb_en   = dec_writes_reg;
          pc_en   = 1'b1;
          irq_ack = irq;
        end
        default: ;
      endcase
    end
  end

  assign stage       = stage_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: per-cycle stage/strobe expectations are queued as
// stimulus is driven and popped when the outputs are sampled.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        imem_ready = 1'b0, dec_is_mem = 1'b0, dec_is_halt = 1'b0;
  logic        dec_writes_reg = 1'b0, dmem_ready = 1'b0, irq = 1'b0;
  logic        imem_req, ir_load, reg_read_en, alu_en, dmem_req, wb_en, pc_en, irq_ack;
  logic        halted, fault;
  logic [2:0]  stage;
  logic [31:0] cycle_count, instr_count;
  logic [7:0]  strobes;

  // Input bits: {imem_ready, dec_is_mem, dec_is_halt, dec_writes_reg, dmem_ready, irq}
  localparam logic [5:0] I_RDY = 6'b100000, I_MEM = 6'b010000, I_HALT = 6'b001000;
  localparam logic [5:0] I_WR = 6'b000100, I_DRDY = 6'b000010, I_IRQ = 6'b000001;
  // Strobe bits: {imem_req, ir_load, reg_read_en, alu_en, dmem_req, wb_en, pc_en, irq_ack}

  typedef struct {
    logic [5:0] in;
    logic [2:0] stg;
    logic [7:0] strb;
    string      tag;
  } stim_t;

  typedef struct {
    logic [2:0] stg;
    logic [7:0] strb;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  multicycle_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(32), .SKIP_MEM(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .imem_ready(imem_ready), .dec_is_mem(dec_is_mem),
    .dec_is_halt(dec_is_halt), .dec_writes_reg(dec_writes_reg), .dmem_ready(dmem_ready),
    .irq(irq), .imem_req(imem_req), .ir_load(ir_load), .reg_read_en(reg_read_en),
    .alu_en(alu_en), .dmem_req(dmem_req), .wb_en(wb_en), .pc_en(pc_en), .irq_ack(irq_ack),
    .halted(halted), .fault(fault), .stage(stage), .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  assign strobes = {imem_req, ir_load, reg_read_en, alu_en, dmem_req, wb_en, pc_en, irq_ack};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected run to finish");
    $fatal(1);
  end

  function automatic stim_t mk(input logic [5:0] in, input logic [2:0] stg,
                               input logic [7:0] strb, input string tag);
    stim_t s;
    s.in = in; s.stg = stg; s.strb = strb; s.tag = tag;
    return s;
  endfunction

  task automatic set_inputs(input logic [5:0] in);
    {imem_ready, dec_is_mem, dec_is_halt, dec_writes_reg, dmem_ready, irq} = in;
  endtask

  // Drive one cycle of stimulus at the falling edge and queue what the outputs must show.
  task automatic drive_cycle(input stim_t s);
    exp_t e;
    @(negedge clk);
    set_inputs(s.in);
    e.stg = s.stg; e.strb = s.strb; e.tag = s.tag;
    sbq.push_back(e);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    n_rst = 1'b0;
    set_inputs(6'b0);
    repeat (2) @(posedge clk);
    #2 n_rst = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_rst = 1'b0;
    set_inputs(I_RDY | I_IRQ);
    #1;
    n_cmp++;
    if (stage !== 3'd0 || strobes !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outputs: stage=%0d strobes=%b, expected stage=0 strobes=00000000", stage, strobes);
    end
    n_cmp++;
    if (halted !== 1'b0 || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: halted=%b fault=%b, expected 0 0", halted, fault);
    end
    n_cmp++;
    if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_counters: cycles=%0d instrs=%0d, expected 0 0", cycle_count, instr_count);
    end
  endtask

  task automatic test_alu_seq;
    stim_t plan[$];
    exp_t  e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      logic [5:0] w;
      w = (i == 1) ? 6'b0 : I_WR;
      plan.push_back(mk(I_RDY | w, 3'd0, 8'hC0, "alu_fetch"));
      plan.push_back(mk(w, 3'd1, 8'h20, "alu_decode"));
      plan.push_back(mk(w, 3'd2, 8'h10, "alu_execute"));
      plan.push_back(mk(w, 3'd4, (i == 1) ? 8'h02 : 8'h06, "alu_writeback"));
    end
    foreach (plan[k]) begin
      drive_cycle(plan[k]);
      e = sbq.pop_front();
      n_cmp++;
      if (stage !== e.stg || strobes !== e.strb) begin
        n_bad++;
        $display("FAIL %s cycle %0d: stage=%0d strobes=%b, expected stage=%0d strobes=%b",
                 e.tag, k + 1, stage, strobes, e.stg, e.strb);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (instr_count !== 32'd3 || cycle_count !== 32'd12 || stage !== 3'd0) begin
      n_bad++;
      $display("FAIL alu_counts: instrs=%0d cycles=%0d stage=%0d, expected 3 12 0",
               instr_count, cycle_count, stage);
    end
  endtask

  task automatic test_mem_wait;
    stim_t plan[$];
    exp_t  e;
    do_reset();
    plan.push_back(mk(I_RDY | I_MEM | I_WR, 3'd0, 8'hC0, "mem_fetch"));
    plan.push_back(mk(I_MEM | I_WR, 3'd1, 8'h20, "mem_decode"));
    plan.push_back(mk(I_MEM | I_WR, 3'd2, 8'h10, "mem_execute"));
    for (int i = 0; i < 3; i++) plan.push_back(mk(I_MEM | I_WR, 3'd3, 8'h08, "mem_wait"));
    plan.push_back(mk(I_MEM | I_WR | I_DRDY, 3'd3, 8'h08, "mem_ready"));
    plan.push_back(mk(I_MEM | I_WR, 3'd4, 8'h06, "mem_writeback"));
    foreach (plan[k]) begin
      drive_cycle(plan[k]);
      e = sbq.pop_front();
      n_cmp++;
      if (stage !== e.stg || strobes !== e.strb) begin
        n_bad++;
        $display("FAIL %s cycle %0d: stage=%0d strobes=%b, expected stage=%0d strobes=%b",
                 e.tag, k + 1, stage, strobes, e.stg, e.strb);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (instr_count !== 32'd1 || cycle_count !== 32'd8 || stage !== 3'd0) begin
      n_bad++;
      $display("FAIL mem_counts: instrs=%0d cycles=%0d stage=%0d, expected 1 8 0",
               instr_count, cycle_count, stage);
    end
  endtask

  task automatic test_fetch_timeout;
    stim_t plan[$];
    exp_t  e;
    do_reset();
    for (int i = 0; i < 16; i++) plan.push_back(mk(I_WR, 3'd0, 8'h80, "tmo_wait"));
    for (int i = 0; i < 4; i++) plan.push_back(mk(I_RDY | I_IRQ | I_WR, 3'd5, 8'h00, "tmo_halted"));
    foreach (plan[k]) begin
      drive_cycle(plan[k]);
      e = sbq.pop_front();
      n_cmp++;
      if (stage !== e.stg || strobes !== e.strb) begin
        n_bad++;
        $display("FAIL %s cycle %0d: stage=%0d strobes=%b, expected stage=%0d strobes=%b",
                 e.tag, k + 1, stage, strobes, e.stg, e.strb);
      end
    end
    n_cmp++;
    if (fault !== 1'b1 || halted !== 1'b1 || cycle_count !== 32'd16 || instr_count !== 32'd0) begin
      n_bad++;
      $display("FAIL tmo_flags: fault=%b halted=%b cycles=%0d instrs=%0d, expected 1 1 16 0",
               fault, halted, cycle_count, instr_count);
    end
  endtask

  task automatic test_ready_at_limit;
    stim_t plan[$];
    exp_t  e;
    do_reset();
    for (int i = 0; i < 15; i++) plan.push_back(mk(6'b0, 3'd0, 8'h80, "edge_wait"));
    plan.push_back(mk(I_RDY, 3'd0, 8'hC0, "edge_ready16"));
    plan.push_back(mk(6'b0, 3'd1, 8'h20, "edge_decode"));
    foreach (plan[k]) begin
      drive_cycle(plan[k]);
      e = sbq.pop_front();
      n_cmp++;
      if (stage !== e.stg || strobes !== e.strb) begin
        n_bad++;
        $display("FAIL %s cycle %0d: stage=%0d strobes=%b, expected stage=%0d strobes=%b",
                 e.tag, k + 1, stage, strobes, e.stg, e.strb);
      end
    end
    n_cmp++;
    if (fault !== 1'b0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL edge_flags: fault=%b halted=%b, expected 0 0", fault, halted);
    end
  endtask

  task automatic test_mem_timeout;
    stim_t plan[$];
    exp_t  e;
    do_reset();
    plan.push_back(mk(I_RDY | I_MEM, 3'd0, 8'hC0, "dtmo_fetch"));
    plan.push_back(mk(I_MEM, 3'd1, 8'h20, "dtmo_decode"));
    plan.push_back(mk(I_MEM, 3'd2, 8'h10, "dtmo_execute"));
    for (int i = 0; i < 16; i++) plan.push_back(mk(I_MEM, 3'd3, 8'h08, "dtmo_wait"));
    for (int i = 0; i < 2; i++) plan.push_back(mk(I_MEM | I_DRDY, 3'd5, 8'h00, "dtmo_halted"));
    foreach (plan[k]) begin
      drive_cycle(plan[k]);
      e = sbq.pop_front();
      n_cmp++;
      if (stage !== e.stg || strobes !== e.strb) begin
        n_bad++;
        $display("FAIL %s cycle %0d: stage=%0d strobes=%b, expected stage=%0d strobes=%b",
                 e.tag, k + 1, stage, strobes, e.stg, e.strb);
      end
    end
    n_cmp++;
    if (fault !== 1'b1 || halted !== 1'b1 || cycle_count !== 32'd19 || instr_count !== 32'd0) begin
      n_bad++;
      $display("FAIL dtmo_flags: fault=%b halted=%b cycles=%0d instrs=%0d, expected 1 1 19 0",
               fault, halted, cycle_count, instr_count);
    end
  endtask

  task automatic test_irq;
    stim_t plan[$];
    exp_t  e;
    do_reset();
    plan.push_back(mk(I_RDY | I_WR, 3'd0, 8'hC0, "irq0_fetch"));
    plan.push_back(mk(I_WR, 3'd1, 8'h20, "irq0_decode"));
    plan.push_back(mk(I_WR | I_IRQ, 3'd2, 8'h10, "irq0_execute"));
    plan.push_back(mk(I_WR | I_IRQ, 3'd4, 8'h07, "irq0_writeback"));
    plan.push_back(mk(I_RDY | I_WR | I_IRQ, 3'd0, 8'hC0, "irq1_fetch"));
    plan.push_back(mk(I_WR | I_IRQ, 3'd1, 8'h20, "irq1_decode"));
    plan.push_back(mk(I_WR | I_IRQ, 3'd2, 8'h10, "irq1_execute"));
    plan.push_back(mk(I_WR | I_IRQ, 3'd4, 8'h07, "irq1_writeback"));
    plan.push_back(mk(I_RDY | I_WR, 3'd0, 8'hC0, "irq2_fetch"));
    plan.push_back(mk(I_WR, 3'd1, 8'h20, "irq2_decode"));
    plan.push_back(mk(I_WR, 3'd2, 8'h10, "irq2_execute"));
    plan.push_back(mk(I_WR, 3'd4, 8'h06, "irq2_writeback"));
    foreach (plan[k]) begin
      drive_cycle(plan[k]);
      e = sbq.pop_front();
      n_cmp++;
      if (stage !== e.stg || strobes !== e.strb) begin
        n_bad++;
        $display("FAIL %s cycle %0d: stage=%0d strobes=%b, expected stage=%0d strobes=%b",
                 e.tag, k + 1, stage, strobes, e.stg, e.strb);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (instr_count !== 32'd3 || cycle_count !== 32'd12) begin
      n_bad++;
      $display("FAIL irq_counts: instrs=%0d cycles=%0d, expected 3 12", instr_count, cycle_count);
    end
  endtask

  task automatic test_halt_then_reset;
    stim_t plan[$];
    exp_t  e;
    do_reset();
    plan.push_back(mk(I_RDY | I_HALT, 3'd0, 8'hC0, "halt_fetch"));
    plan.push_back(mk(I_HALT, 3'd1, 8'h20, "halt_decode"));
    for (int i = 0; i < 3; i++) plan.push_back(mk(I_RDY | I_IRQ | I_WR, 3'd5, 8'h00, "halt_stay"));
    foreach (plan[k]) begin
      drive_cycle(plan[k]);
      e = sbq.pop_front();
      n_cmp++;
      if (stage !== e.stg || strobes !== e.strb) begin
        n_bad++;
        $display("FAIL %s cycle %0d: stage=%0d strobes=%b, expected stage=%0d strobes=%b",
                 e.tag, k + 1, stage, strobes, e.stg, e.strb);
      end
    end
    n_cmp++;
    if (halted !== 1'b1 || fault !== 1'b0 || instr_count !== 32'd1 || cycle_count !== 32'd2) begin
      n_bad++;
      $display("FAIL halt_state: halted=%b fault=%b instrs=%0d cycles=%0d, expected 1 0 1 2",
               halted, fault, instr_count, cycle_count);
    end

    do_reset();
    plan.delete();
    plan.push_back(mk(I_RDY | I_MEM | I_WR, 3'd0, 8'hC0, "rst_fetch"));
    plan.push_back(mk(I_MEM | I_WR, 3'd1, 8'h20, "rst_decode"));
    plan.push_back(mk(I_MEM | I_WR, 3'd2, 8'h10, "rst_execute"));
    plan.push_back(mk(I_MEM | I_WR, 3'd3, 8'h08, "rst_memory"));
    plan.push_back(mk(I_MEM | I_WR, 3'd3, 8'h08, "rst_memory"));
    foreach (plan[k]) begin
      drive_cycle(plan[k]);
      e = sbq.pop_front();
      n_cmp++;
      if (stage !== e.stg || strobes !== e.strb) begin
        n_bad++;
        $display("FAIL %s cycle %0d: stage=%0d strobes=%b, expected stage=%0d strobes=%b",
                 e.tag, k + 1, stage, strobes, e.stg, e.strb);
      end
    end
    n_rst = 1'b0;
    dmem_ready = 1'b1;
    #1;
    n_cmp++;
    if (stage !== 3'd0 || strobes !== 8'h00 || halted !== 1'b0 || fault !== 1'b0 ||
        cycle_count !== 32'd0 || instr_count !== 32'd0) begin
      n_bad++;
      $display("FAIL midmem_reset: stage=%0d strobes=%b halted=%b fault=%b cycles=%0d instrs=%0d, expected 0 00000000 0 0 0 0",
               stage, strobes, halted, fault, cycle_count, instr_count);
    end
    @(posedge clk);
    #2 n_rst = 1'b1;
    set_inputs(6'b0);
    @(negedge clk); #1;
    n_cmp++;
    if (stage !== 3'd0 || strobes !== 8'h80 || instr_count !== 32'd0) begin
      n_bad++;
      $display("FAIL post_reset: stage=%0d strobes=%b instrs=%0d, expected 0 10000000 0",
               stage, strobes, instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu_seq();
    test_mem_wait();
    test_fetch_timeout();
    test_ready_at_limit();
    test_mem_timeout();
    test_irq();
    test_halt_then_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
